// File: rtl/alu_muldiv_control.sv
// ALU function decode for the execute stage, plus an iterative RV32M/RV64M unit
// (shift-add multiplier, restoring divider) that stalls execute until its result is ready.
module alu_muldiv_control #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            kill,
    input  logic [1:0]      alu_op_type,
    input  logic [2:0]      inst_funct3,
    input  logic [6:0]      inst_funct7,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [4:0]      alu_function,
    output logic            is_muldiv,
    output logic            stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam logic [1:0] CTL_ALU_ADD    = 2'b00;
    localparam logic [1:0] CTL_ALU_OP     = 2'b01;
    localparam logic [1:0] CTL_ALU_OP_IMM = 2'b10;
    localparam logic [1:0] CTL_ALU_BRANCH = 2'b11;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SLL  = 5'b00011;
    localparam logic [4:0] ALU_SLT  = 5'b00100;
    localparam logic [4:0] ALU_SLTU = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_OR   = 5'b01001;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_SEQ  = 5'b01011;

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_UNROLL - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;
    logic [2*XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [XLEN-1:0]     result_q, result_d;

    // ---------------- decode ----------------
    logic [4:0] default_fn, secondary_fn, branch_fn;

    assign is_muldiv = (alu_op_type == CTL_ALU_OP) && (inst_funct7 == 7'b0000001);

    always_comb begin
        default_fn = ALU_ADD;
        case (inst_funct3)
            3'b000:  default_fn = ALU_ADD;
            3'b001:  default_fn = ALU_SLL;
            3'b010:  default_fn = ALU_SLT;
            3'b011:  default_fn = ALU_SLTU;
            3'b100:  default_fn = ALU_XOR;
            3'b101:  default_fn = ALU_SRL;
            3'b110:  default_fn = ALU_OR;
            default: default_fn = ALU_AND;
        endcase

        secondary_fn = default_fn;
        if (inst_funct3 == 3'b000)
            secondary_fn = ALU_SUB;
        else if (inst_funct3 == 3'b101)
            secondary_fn = ALU_SRA;

        branch_fn = ALU_ADD;
        case (inst_funct3)
            3'b000, 3'b001: branch_fn = ALU_SEQ;
            3'b100, 3'b101: branch_fn = ALU_SLT;
            3'b110, 3'b111: branch_fn = ALU_SLTU;
            default:        branch_fn = ALU_ADD;
        endcase

        alu_function = ALU_ADD;
        case (alu_op_type)
            CTL_ALU_OP:     alu_function = inst_funct7[5] ? secondary_fn : default_fn;
            // Only SRAI has an alternate form; funct7[5] is otherwise immediate data.
            CTL_ALU_OP_IMM: alu_function = (inst_funct7[5] && inst_funct3[1:0] == 2'b01)
                                           ? secondary_fn : default_fn;
            CTL_ALU_BRANCH: alu_function = branch_fn;
            default:        alu_function = ALU_ADD;
        endcase
        if (is_muldiv)
            alu_function = ALU_ADD;
    end

    // ---------------- operand preparation at accept ----------------
    logic            signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_overflow;

    always_comb begin
        signed_a     = inst_funct3[2] ? ~inst_funct3[0] : (inst_funct3[1:0] != 2'b11);
        signed_b     = inst_funct3[2] ? ~inst_funct3[0] : ~inst_funct3[1];
        sign_a       = signed_a & operand_a[XLEN-1];
        sign_b       = signed_b & operand_b[XLEN-1];
        abs_a        = sign_a ? -operand_a : operand_a;
        abs_b        = sign_b ? -operand_b : operand_b;
        div_by_zero  = (operand_b == '0);
        div_overflow = signed_b && (operand_a == MIN_NEG) && (operand_b == '1);
    end

    // ---------------- iterative datapath ----------------
    logic [2*XLEN-1:0] pp [MUL_UNROLL];
    logic [2*XLEN-1:0] pp_sum;

    for (genvar gi = 0; gi < MUL_UNROLL; gi++) begin : g_pp
        assign pp[gi] = b_q[gi] ? (a_q << gi) : '0;
    end

    always_comb begin
        pp_sum = '0;
        for (int i = 0; i < MUL_UNROLL; i++)
            pp_sum = pp_sum + pp[i];
    end

    logic [XLEN:0] div_shift, div_diff;
    logic          div_bit;

    always_comb begin
        div_shift = {rem_q, a_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        div_bit   = ~div_diff[XLEN];
    end

    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quot_signed, rem_signed, done_value;

    always_comb begin
        prod_signed = neg_q ? -acc_q : acc_q;
        quot_signed = neg_q ? -a_q[XLEN-1:0] : a_q[XLEN-1:0];
        rem_signed  = rneg_q ? -rem_q : rem_q;
        case (op_q)
            3'd0:             done_value = prod_signed[XLEN-1:0];
            3'd1, 3'd2, 3'd3: done_value = prod_signed[2*XLEN-1:XLEN];
            3'd4, 3'd5:       done_value = quot_signed;
            default:          done_value = rem_signed;
        endcase
    end

    // ---------------- control FSM ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (valid_in && is_muldiv) begin
                    op_d    = inst_funct3;
                    neg_d   = sign_a ^ sign_b;
                    rneg_d  = sign_a;
                    a_d     = {{XLEN{1'b0}}, abs_a};
                    b_d     = abs_b;
                    rem_d   = '0;
                    acc_d   = '0;
                    count_d = '0;
                    if (!inst_funct3[2]) begin
                        state_d = MUL;
                    end else if (div_by_zero) begin
                        // Final values are stored unsigned so DONE leaves them untouched.
                        a_d     = {{XLEN{1'b0}}, {XLEN{1'b1}}};
                        rem_d   = operand_a;
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else if (div_overflow) begin
                        a_d     = {{XLEN{1'b0}}, operand_a};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d   = acc_q + pp_sum;
                a_d     = a_q << MUL_UNROLL;
                b_d     = b_q >> MUL_UNROLL;
                count_d = count_q + 1'b1;
                if (count_q == MUL_LAST)
                    state_d = DONE;
            end
            DIV: begin
                // Dividend shifts out of a_q's top while quotient bits shift in at the bottom.
                rem_d   = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                a_d     = {{XLEN{1'b0}}, a_q[XLEN-2:0], div_bit};
                count_d = count_q + 1'b1;
                if (count_q == DIV_LAST)
                    state_d = DONE;
            end
            default: begin
                result_d = done_value;
                state_d  = IDLE;
            end
        endcase

        if (kill)
            state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign result_valid = (state_q == DONE);
    assign result       = (state_q == DONE) ? done_value : result_q;
    assign stall        = valid_in && is_muldiv && (state_q != DONE);

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Scoreboard bench: drivers queue expected M-op results, monitors check value and arrival cycle.
module tb_alu_muldiv_control;

    localparam logic [1:0] CTL_ALU_ADD    = 2'b00;
    localparam logic [1:0] CTL_ALU_OP     = 2'b01;
    localparam logic [1:0] CTL_ALU_OP_IMM = 2'b10;
    localparam logic [1:0] CTL_ALU_BRANCH = 2'b11;

    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SUB  = 5'b00010;
    localparam logic [4:0] ALU_SLL  = 5'b00011;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_AND  = 5'b01010;
    localparam logic [4:0] ALU_SEQ  = 5'b01011;
    localparam logic [4:0] ALU_SLT  = 5'b00100;
    localparam logic [4:0] ALU_SLTU = 5'b00101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        valid_in4 = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  alu_op_type = CTL_ALU_ADD;
    logic [2:0]  inst_funct3 = 3'b000;
    logic [6:0]  inst_funct7 = 7'b0000000;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;

    logic [4:0]  alu_function, alu_function4;
    logic        is_muldiv, is_muldiv4;
    logic        stall, stall4;
    logic [31:0] result, result4;
    logic        result_valid, result_valid4;

    alu_muldiv_control #(.XLEN(32), .MUL_UNROLL(1)) u_dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .kill(kill),
        .alu_op_type(alu_op_type), .inst_funct3(inst_funct3), .inst_funct7(inst_funct7),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_function(alu_function), .is_muldiv(is_muldiv), .stall(stall),
        .result(result), .result_valid(result_valid)
    );

    alu_muldiv_control #(.XLEN(32), .MUL_UNROLL(4)) u_dut4 (
        .clock(clock), .reset(reset), .valid_in(valid_in4), .kill(kill),
        .alu_op_type(alu_op_type), .inst_funct3(inst_funct3), .inst_funct7(inst_funct7),
        .operand_a(operand_a), .operand_b(operand_b),
        .alu_function(alu_function4), .is_muldiv(is_muldiv4), .stall(stall4),
        .result(result4), .result_valid(result_valid4)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          cyc;
    } txn_t;

    txn_t q1[$];
    txn_t q4[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor for the MUL_UNROLL=1 instance.
    always @(negedge clock) begin
        txn_t t;
        if (result_valid !== 1'b0) begin
            if (q1.size() == 0) begin
                check("unexpected result_valid (unroll1)", {31'b0, result_valid}, 32'h0);
            end else begin
                t = q1.pop_front();
                $display("txn %s: result=%h cycle=%0d (expected %h at %0d)",
                         t.name, result, cyc, t.val, t.cyc);
                check({t.name, " value"}, result, t.val);
                check({t.name, " cycle"}, cyc, t.cyc);
            end
        end
    end

    // Monitor for the MUL_UNROLL=4 instance.
    always @(negedge clock) begin
        txn_t t;
        if (result_valid4 !== 1'b0) begin
            if (q4.size() == 0) begin
                check("unexpected result_valid (unroll4)", {31'b0, result_valid4}, 32'h0);
            end else begin
                t = q4.pop_front();
                $display("txn %s: result=%h cycle=%0d (expected %h at %0d)",
                         t.name, result4, cyc, t.val, t.cyc);
                check({t.name, " value"}, result4, t.val);
                check({t.name, " cycle"}, cyc, t.cyc);
            end
        end
    end

    // Present one M-op, queue its expectation, hold it until stall drops (the DONE cycle).
    task automatic run_mop(input bit use4, input string name, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat);
        txn_t t;
        int   n;
        @(posedge clock); #1;
        alu_op_type = CTL_ALU_OP;
        inst_funct7 = 7'b0000001;
        inst_funct3 = f3;
        operand_a   = a;
        operand_b   = b;
        valid_in    = !use4;
        valid_in4   = use4;
        t.name = name;
        t.val  = exp;
        t.cyc  = cyc + lat;
        if (use4) q4.push_back(t);
        else      q1.push_back(t);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((use4 ? stall4 : stall) !== 1'b1) break;
            n++;
        end
        check({name, " stall cycles"}, n, lat);
    endtask

    task automatic drop_valid();
        @(posedge clock); #1;
        valid_in  = 1'b0;
        valid_in4 = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] fn;
    } dec_t;

    dec_t dec_tab[13] = '{
        '{"SUB",    CTL_ALU_OP,     3'b000, 7'b0100000, ALU_SUB},
        '{"SRA",    CTL_ALU_OP,     3'b101, 7'b0100000, ALU_SRA},
        '{"ADD",    CTL_ALU_OP,     3'b000, 7'b0000000, ALU_ADD},
        '{"AND",    CTL_ALU_OP,     3'b111, 7'b0000000, ALU_AND},
        '{"SRAI",   CTL_ALU_OP_IMM, 3'b101, 7'b0100000, ALU_SRA},
        '{"ADDI_i", CTL_ALU_OP_IMM, 3'b000, 7'b0100000, ALU_ADD},
        '{"SLLI",   CTL_ALU_OP_IMM, 3'b001, 7'b0000000, ALU_SLL},
        '{"BEQ",    CTL_ALU_BRANCH, 3'b000, 7'b0000000, ALU_SEQ},
        '{"BNE",    CTL_ALU_BRANCH, 3'b001, 7'b0000000, ALU_SEQ},
        '{"BLT",    CTL_ALU_BRANCH, 3'b100, 7'b0000000, ALU_SLT},
        '{"BGE",    CTL_ALU_BRANCH, 3'b101, 7'b0000000, ALU_SLT},
        '{"BGEU",   CTL_ALU_BRANCH, 3'b111, 7'b0000000, ALU_SLTU},
        '{"ADDCTL", CTL_ALU_ADD,    3'b110, 7'b0100000, ALU_ADD}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset result_valid", {31'b0, result_valid}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset stall", {31'b0, stall}, 32'h0);
        reset = 1'b0;

        // Back-to-back multiplies and divides
        run_mop(0, "MUL 7*-3",        3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_mop(0, "MULHU -1*-1",     3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_mop(0, "MULH -1*-1",      3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_mop(0, "MULHSU -1*2",     3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
        run_mop(0, "MULHU 2^16*2^16", 3'd3, 32'h00010000, 32'h00010000, 32'h00000001, 33);
        run_mop(0, "MUL 2^16*2^16",   3'd0, 32'h00010000, 32'h00010000, 32'h00000000, 33);
        run_mop(0, "DIV -20/3",       3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
        run_mop(0, "REM -20/3",       3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
        run_mop(0, "DIVU 100/7",      3'd5, 32'd100,      32'd7,        32'd14,       33);
        run_mop(0, "REMU 100/7",      3'd7, 32'd100,      32'd7,        32'd2,        33);
        run_mop(0, "DIVU min/-1",     3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        // Special cases
        run_mop(0, "DIV 5/0",         3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_mop(0, "REM 5/0",         3'd6, 32'd5,        32'd0,        32'd5,        1);
        run_mop(0, "DIVU 5/0",        3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_mop(0, "DIV min/-1",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_mop(0, "REM min/-1",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        drop_valid();

        // kill a divide mid-flight: no result may appear
        @(posedge clock); #1;
        alu_op_type = CTL_ALU_OP;
        inst_funct7 = 7'b0000001;
        inst_funct3 = 3'd4;
        operand_a   = 32'd1000;
        operand_b   = 32'd3;
        valid_in    = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        kill     = 1'b1;
        valid_in = 1'b0;
        @(posedge clock); #1;
        kill = 1'b0;
        repeat (40) @(posedge clock);
        run_mop(0, "MUL 3*4 after kill", 3'd0, 32'd3, 32'd4, 32'd12, 33);
        drop_valid();

        // reset in the middle of a multiply
        @(posedge clock); #1;
        inst_funct3 = 3'd0;
        operand_a   = 32'd9;
        operand_b   = 32'd9;
        valid_in    = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("mid-MUL reset result_valid", {31'b0, result_valid}, 32'h0);
        check("mid-MUL reset result", result, 32'h0);
        repeat (40) @(posedge clock);

        // MUL_UNROLL=4 instance
        run_mop(1, "U4 MUL 7*-3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9);
        run_mop(1, "U4 MULH min*min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 9);
        drop_valid();

        // Decode table; valid_in held high, so any stall or state change would show.
        foreach (dec_tab[i]) begin
            @(posedge clock); #1;
            alu_op_type = dec_tab[i].op;
            inst_funct3 = dec_tab[i].f3;
            inst_funct7 = dec_tab[i].f7;
            valid_in    = 1'b1;
            #1;
            $display("txn decode %s: alu_function=%b stall=%b is_muldiv=%b",
                     dec_tab[i].name, alu_function, stall, is_muldiv);
            check({"decode ", dec_tab[i].name, " fn"}, {27'b0, alu_function}, {27'b0, dec_tab[i].fn});
            check({"decode ", dec_tab[i].name, " stall"}, {31'b0, stall}, 32'h0);
            check({"decode ", dec_tab[i].name, " is_muldiv"}, {31'b0, is_muldiv}, 32'h0);
        end
        @(posedge clock); #1;
        valid_in    = 1'b0;
        alu_op_type = CTL_ALU_OP;
        inst_funct3 = 3'b000;
        inst_funct7 = 7'b0000001;
        #1;
        $display("txn decode MUL (not valid): alu_function=%b stall=%b is_muldiv=%b",
                 alu_function, stall, is_muldiv);
        check("decode MUL is_muldiv", {31'b0, is_muldiv}, 32'h1);
        check("decode MUL fn", {27'b0, alu_function}, {27'b0, ALU_ADD});
        check("decode MUL stall without valid", {31'b0, stall}, 32'h0);

        repeat (5) @(posedge clock);
        #1;
        check("scoreboard unroll1 drained", q1.size(), 32'h0);
        check("scoreboard unroll4 drained", q4.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_control.md
Name: alu_muldiv_control

Overview:
Parametrised successor to the single-cycle ALU controller for the rvsimple core. It keeps the base RV32I ALU-function decode and adds RV32M/RV64M support: it detects MUL/DIV/REM instructions and runs them on an internal iterative shift-add multiplier and restoring divider. While an M-extension operation runs, it stalls the execute stage and then delivers the result with a one-cycle valid pulse. It sits in execute beside the ALU; the writeback mux selects its result when is_muldiv is high.

Parameters:
XLEN, 32, operand/result width (32 or 64)
MUL_UNROLL, 1, multiplier bits retired per cycle (1, 2 or 4; must divide XLEN)

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
valid_in  input  1  execute stage holds a valid instruction
kill  input  1  abort in-flight operation (pipeline flush)
alu_op_type  input  2  CTL_ALU_* class from main decoder
inst_funct3  input  3  instruction funct3
inst_funct7  input  7  instruction funct7
operand_a  input  XLEN  rs1 value
operand_b  input  XLEN  rs2 value
alu_function  output  5  ALU_* code for the single-cycle ALU
is_muldiv  output  1  current instruction is an M-extension op
stall  output  1  hold the pipeline this cycle
result  output  XLEN  M-extension result
result_valid  output  1  result is valid this cycle (one-cycle pulse)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset forces state IDLE; result=0, result_valid=0; all counters and accumulators cleared. Reset mid-operation abandons the operation with no result pulse.
- Decode (combinational):
  - alu_function uses the base mapping. CTL_ALU_ADD->ALU_ADD. CTL_ALU_OP: funct7[5] selects SUB/SRA over ADD/SRL. CTL_ALU_OP_IMM: the secondary function is used only when funct7[5] is set and funct3[1:0]==01. CTL_ALU_BRANCH: EQ/NE->ALU_SEQ, LT/GE->ALU_SLT, LTU/GEU->ALU_SLTU.
  - is_muldiv = (alu_op_type==CTL_ALU_OP) && (funct7==7'b0000001). When it is high, alu_function is driven as ALU_ADD (don't-care for the datapath).
- Opcode map (funct3): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States:
  - IDLE: when valid_in&&is_muldiv, latch the operands, their signs and funct3.
    - Divide with operand_b==0: go to DONE. Quotient is all ones; remainder is operand_a.
    - Signed DIV/REM with operand_a==min and operand_b==-1: go to DONE. Quotient is operand_a; remainder is 0.
    - Otherwise go to MUL or DIV with count=0.
  - MUL: each cycle, add MUL_UNROLL shifted partial products of |a|*|b| into a 2*XLEN accumulator. After XLEN/MUL_UNROLL cycles, go to DONE.
  - DIV: restoring unsigned division of |a| by |b|, one quotient bit per cycle. After XLEN cycles, go to DONE.
  - DONE: apply signs.
    - Product is negated when the operand signs differ; MULHSU treats b as unsigned; MULHU/DIVU/REMU use raw operands.
    - Quotient sign = sa^sb; remainder sign = sa.
    - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
    - result_valid=1 for this single cycle, then go to IDLE.
- Latency: accept at cycle T. Multiply gives result_valid at T+XLEN/MUL_UNROLL+1; divide at T+XLEN+1; special cases at T+1.
- stall = valid_in && is_muldiv && state!=DONE. Stall is therefore high from T until the cycle before result_valid, and low in the DONE cycle.
- result holds its last value outside DONE; consumers must qualify it with result_valid.
- kill: any state goes to IDLE next cycle, with no result_valid. kill has priority over a new accept in the same cycle. reset has priority over kill.
- Back-to-back: an M-op presented in the cycle after DONE is accepted normally from IDLE.
- Non-M instructions never change state and never assert stall.
- All arithmetic is unsigned internally at 2*XLEN width, so no overflow is lost.

Test Plan:
- XLEN=32, MUL_UNROLL=1: MUL a=7, b=0xFFFFFFFD. stall is high for 33 cycles (T through T+32), then result_valid=1 at T+33 with result=0xFFFFFFEB.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFE. MULH on the same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> quotient 0xFFFFFFFA at T+33. REM a=-20, b=3 -> 0xFFFFFFFE. DIVU a=100, b=7 -> 14.
- Special cases, each giving result_valid at T+1: DIV by zero with a=5 -> 0xFFFFFFFF; REM by zero -> 5; DIV 0x80000000 by -1 -> 0x80000000; REM 0x80000000 by -1 -> 0.
- kill asserted at T+10 of a DIV -> state returns to IDLE at T+11, no result_valid pulse. A following MUL 3*4 -> 12.
- MUL_UNROLL=4: MUL 7*-3 -> 0xFFFFFFEB at T+9.
- Decode: SUB/SRA/SRAI/branch codes match the base table with stall=0. reset asserted mid-MUL -> result_valid=0, result=0 next cycle.
